// File: rtl/mul_final_cpa_if.sv
// Handshake bundle for the multiplier final CPA: tree sum/carry in, product out.
// master drives operands and out_ready; slave is the adder.
interface mul_final_cpa_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;

  modport master (
    output in_valid, sum_vec, carry_vec, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, sum_vec, carry_vec, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul_final_cpa.sv
// Two-stage split carry-propagate adder resolving the Wallace-tree sum/carry pair.
// Optional MUL_FINAL_CPA_SKID_EN adds a 2-entry output buffer behind stage 2.
module mul_final_cpa #(
  parameter int WIDTH = 64,
  parameter int SPLIT = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  mul_final_cpa_if.slave io
);
  localparam int HI = WIDTH - SPLIT;

  logic [WIDTH-1:0] b_op;
  logic [SPLIT:0]   lo_sum;
  logic             s1_en;
  logic             s2_en;
  logic             unused_carry_msb;

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             c1_q, c1_d;
  logic [HI-1:0]    a_hi_q, a_hi_d;
  logic [HI-1:0]    b_hi_q, b_hi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_prod_q, s2_prod_d;

  // The top tree carry would land at weight 2^WIDTH, outside the product.
  assign unused_carry_msb = io.carry_vec[WIDTH-1];
  assign b_op   = {io.carry_vec[WIDTH-2:0], 1'b0};
  assign lo_sum = {1'b0, io.sum_vec[SPLIT-1:0]}
                + {1'b0, b_op[SPLIT-1:0]};

  assign s1_en       = !s1_valid_q || s2_en;
  assign io.in_ready = s1_en;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    c1_d       = c1_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    if (s1_en) begin
      s1_valid_d = io.in_valid;
      if (io.in_valid) begin
        s1_lo_d = lo_sum[SPLIT-1:0];
        c1_d    = lo_sum[SPLIT];
        a_hi_d  = io.sum_vec[WIDTH-1:SPLIT];
        b_hi_d  = b_op[WIDTH-1:SPLIT];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = {a_hi_q + b_hi_q + HI'(c1_q), s1_lo_q};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      c1_q       <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      c1_q       <= c1_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
    end
  end

`ifdef MUL_FINAL_CPA_SKID_EN
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // Buffer space comes from registers only, cutting out_ready -> in_ready.
  assign s2_en = (cnt_q < 2'd2);
  assign push  = s2_valid_q && s2_en;
  assign pop   = (cnt_q != 2'd0) && io.out_ready;

  always_comb begin
    buf_d = buf_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) begin
      buf_d[wr_q] = s2_prod_q;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io.out_valid = (cnt_q != 2'd0);
  assign io.product   = buf_q[rd_q];
`else
  assign s2_en        = !s2_valid_q || io.out_ready;
  assign io.out_valid = s2_valid_q;
  assign io.product   = s2_prod_q;
`endif

endmodule

// File: tb/tb_mul_final_cpa.sv
// Directed self-checking bench for mul_final_cpa (default or MUL_FINAL_CPA_SKID_EN build).
// Vector table for single beats plus hand sequences for streaming, stalls and reset.
module tb_mul_final_cpa;
`ifdef MUL_FINAL_CPA_SKID_EN
  localparam int LAT = 3;
  localparam int CAP = 4;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] e;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] s_sum [8];
  logic [63:0] s_car [8];
  logic [63:0] s_exp [8];
  vec_t        vt [8];

  mul_final_cpa_if #(.WIDTH(64)) bus ();

  mul_final_cpa #(.WIDTH(64), .SPLIT(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic stream(input int n, input bit toggle, input bit timed);
    int   sent;
    int   got;
    int   cyc;
    logic pre;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < 80) begin
      @(negedge clock);
      pre = bus.in_ready;
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      bus.in_valid  = (sent < n);
      if (sent < n) begin
        bus.sum_vec   = s_sum[sent];
        bus.carry_vec = s_car[sent];
      end
      #1;
`ifdef MUL_FINAL_CPA_SKID_EN
      if (toggle) check("in_ready_reg_only", 64'(bus.in_ready), 64'(pre));
`endif
      if (!toggle && bus.in_valid) check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        check("stream_product", bus.product, s_exp[got]);
        if (timed) check("stream_cycle", 64'(cyc), 64'(LAT + got));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    check("stream_count", 64'(got), 64'(n));
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    logic [63:0] p0;

    vt[0] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0001};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001};
    vt[2] = '{64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_1236};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vt[4] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000};
    vt[5] = '{64'h0000_0000_7FFF_FFFF, 64'h0000_0000_4000_0000, 64'h0000_0000_FFFF_FFFF};
    vt[6] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vt[7] = '{64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0001_0000_0000};

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum_vec   = '0;
    bus.carry_vec = '0;
    #3;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_product", bus.product, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      s_sum[0] = vt[i].s;
      s_car[0] = vt[i].c;
      s_exp[0] = vt[i].e;
      stream(1, 1'b0, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      s_sum[i] = 64'(i + 1);
      s_car[i] = 64'(i);
    end
    s_exp[0] = 64'd1; s_exp[1] = 64'd4; s_exp[2] = 64'd7; s_exp[3] = 64'd10;
    stream(4, 1'b0, 1'b1);

    s_sum[0] = 64'd5; s_car[0] = 64'd0; s_exp[0] = 64'd5;
    s_sum[1] = 64'd6; s_car[1] = 64'd1; s_exp[1] = 64'd8;
    s_sum[2] = 64'd7; s_car[2] = 64'd2; s_exp[2] = 64'd11;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      bus.out_ready = 1'b0;
      bus.in_valid  = (sent < 3);
      if (sent < 3) begin
        bus.sum_vec   = s_sum[sent];
        bus.carry_vec = s_car[sent];
      end
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(negedge clock);
    #1;
    check("bp_accepted", 64'(sent), 64'((CAP < 3) ? CAP : 3));
    check("bp_in_ready", 64'(bus.in_ready), 64'(CAP > 3));
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_head", bus.product, s_exp[0]);
    p0 = bus.product;
    @(negedge clock);
    #1;
    check("bp_stable", bus.product, p0);
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clock);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 3);
      if (sent < 3) begin
        bus.sum_vec   = s_sum[sent];
        bus.carry_vec = s_car[sent];
      end
      #1;
      if (bus.out_valid) begin
        check("bp_drain", bus.product, s_exp[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    check("bp_drain_count", 64'(got), 64'd3);
    @(negedge clock);
    #1;
    check("bp_no_dup", 64'(bus.out_valid), 64'd0);

    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sum_vec   = 64'h55;
      bus.carry_vec = 64'h0;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    check("rst_full", 64'(bus.out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(bus.out_valid), 64'd0);
    check("rst_async_product", bus.product, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    s_sum[0] = 64'h10; s_car[0] = 64'h8; s_exp[0] = 64'h20;
    stream(1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      s_sum[i] = 64'(3 * i + 1);
      s_car[i] = 64'(i);
      s_exp[i] = 64'(5 * i + 1);
    end
    stream(8, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_final_cpa.md
Name: mul_final_cpa

Overview:
- Final carry-propagate adder stage of the integer multiplier.
- Sits directly downstream of the Wallace-tree column slices and consumes one sum bit and one carry bit per column.
- Resolves the redundant sum/carry pair into the binary product using a 2-stage split adder with a valid/ready handshake.
- Upstream is the tree output register; downstream is the multiplier result/writeback logic.

Parameters:
- WIDTH, 64, product width and number of tree columns.
- SPLIT, 32, width of the low segment added in stage 1; legal range 1..WIDTH-1.

Ports:
- clock  input  1  single clock for all registers.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sum_vec/carry_vec hold a valid tree result.
- in_ready  output  1  block accepts the input this cycle.
- sum_vec  input  WIDTH  per-column sum bits; bit i has weight 2^i.
- carry_vec  input  WIDTH  per-column carry-out bits; bit i has weight 2^(i+1).
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream accepts product this cycle.
- product  output  WIDTH  (sum_vec + (carry_vec << 1)) mod 2^WIDTH.

Behaviour:
- Reset: clock and reset_n only; reset is asynchronous and active-low. While reset_n=0, all valid flags and data registers are 0, so out_valid=0 and product=0. in_ready=1 from the first clock edge after release.
- Accept: a beat is accepted when in_valid and in_ready are both high at the rising edge. Delivery: a beat leaves when out_valid and out_ready are both high.
- Operand formation: addend B = {carry_vec[WIDTH-2:0], 1'b0}. carry_vec[WIDTH-1] is discarded, and so is any carry out of bit WIDTH-1.
- Stage 1 on accept:
  - s1_lo = sum_vec[SPLIT-1:0] + B[SPLIT-1:0], registered together with its carry-out c1.
  - The upper operand halves are registered unchanged.
  - s1_valid is set.
- Stage 2: s2_hi = upper halves + c1; product = {s2_hi, s1_lo}; s2_valid is set.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 beat per cycle.
- Elastic control:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en
- A stage's valid clears when it advances with no incoming valid.
- Data registers load only when their enable is high and the incoming stage is valid; otherwise they hold. While out_valid=1 and out_ready=0, product is stable.
- Full pipeline with out_ready=0: in_ready=0, nothing is accepted, nothing is lost or duplicated.
- Simultaneous accept and delivery in the same cycle: both occur and occupancy is unchanged.
- Order: results leave strictly in acceptance order.
- Reset mid-operation: in-flight beats are dropped. out_valid falls immediately (asynchronously), not at the next edge.

Optional Feature:
- Macro: MUL_FINAL_CPA_SKID_EN.
- Defined:
  - Stage 2 writes into a 2-entry output buffer instead of driving the ports directly.
  - s2_en = (buffer count < 2), computed from registers only, so in_ready has no combinational path from out_ready.
  - Latency becomes 3 cycles.
  - Up to 4 beats can be in flight.
  - product is driven from the buffer head.
- Undefined: the behaviour above, latency 2, combinational path from out_ready to in_ready.

Test Plan:
- Cross-split carry: sum_vec=0x0000_0000_FFFF_FFFF, carry_vec=0x0000_0000_0000_0001, out_ready=1 -> product=0x0000_0001_0000_0001 with out_valid high exactly 2 cycles after accept (3 with macro).
- Wrap: sum_vec=0xFFFF_FFFF_FFFF_FFFF, carry_vec=0x8000_0000_0000_0001 -> product=0x0000_0000_0000_0001; dropped carries are not observable.
- Streaming: 4 beats back-to-back with (sum, carry) = (1,0), (2,1), (3,2), (4,3) and out_ready=1 -> products 1, 4, 7, 10 on consecutive cycles; in_ready stays 1.
- Backpressure:
  - out_ready=0 while offering 3 beats -> exactly 2 accepted, in_ready=0, product stable.
  - Raising out_ready -> all 3 delivered in order, none lost or duplicated.
  - With macro: 4 accepted before in_ready=0.
- Reset during stall: pull reset_n low with a full pipeline -> out_valid=0 and product=0 immediately; after release in_ready=1 and the first new beat completes correctly.
- Macro isolation: with MUL_FINAL_CPA_SKID_EN, toggle out_ready every cycle under continuous input -> in_ready changes only on clock edges, and the result sequence equals the reference sums.
